// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: latches one request, launches the selected
// arithmetic unit, waits for completion (bounded by TIMEOUT) and writes HI/LO.
module md_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic        op_ready,
    output logic        stall,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic        mul_start,
    output logic        mulu_start,
    output logic        div_start,
    output logic        divu_start,
    input  logic        mul_done,
    input  logic        mulu_done,
    input  logic        div_busy,
    input  logic        divu_busy,
    input  logic [63:0] res_mul,
    input  logic [63:0] res_mulu,
    input  logic [31:0] res_q,
    input  logic [31:0] res_r,
    input  logic [31:0] res_qu,
    input  logic [31:0] res_ru,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        hi_ena,
    output logic        lo_ena,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned UNIT_N = 4;

    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_seen_q, busy_seen_d;
    logic [UNIT_N-1:0]   start_q, start_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic                op_ready_q, op_ready_d;
    logic                stall_q, stall_d;

    logic                sel_done_c;
    logic                sel_busy_c;
    logic                complete_c;

    // Only the unit selected by the latched opcode can complete the operation
    assign sel_done_c = (op_q == OP_MULTU) ? mulu_done : mul_done;
    assign sel_busy_c = (op_q == OP_DIVU)  ? divu_busy : div_busy;
    assign complete_c = op_q[1] ? (!sel_busy_c && busy_seen_q) : sel_done_c;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        busy_seen_d = busy_seen_q;
        start_d     = '0;
        wr_d        = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d = op_code;
                    a_d  = rs_value;
                    b_d  = rt_value;
                    // Divide by zero aborts without ever starting a unit
                    if (op_code[1] && (rt_value == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                        start_d = UNIT_N'(1) << op_code;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d       = '0;
                busy_seen_d = 1'b0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[1] && sel_busy_c) begin
                    busy_seen_d = 1'b1;
                end
                if (complete_c) begin
                    case (op_q)
                        2'b00:   begin hi_d = res_mul[63:32];  lo_d = res_mul[31:0];  end
                        2'b01:   begin hi_d = res_mulu[63:32]; lo_d = res_mulu[31:0]; end
                        2'b10:   begin hi_d = res_r;           lo_d = res_q;          end
                        default: begin hi_d = res_ru;          lo_d = res_qu;         end
                    endcase
                    wr_d    = 1'b1;
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        op_ready_d = (state_d == S_IDLE);
        stall_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            busy_seen_q <= 1'b0;
            start_q     <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            op_ready_q  <= 1'b1;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            busy_seen_q <= busy_seen_d;
            start_q     <= start_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            op_ready_q  <= op_ready_d;
            stall_q     <= stall_d;
        end
    end

    assign op_ready   = op_ready_q;
    assign stall      = stall_q;
    assign a_out      = a_q;
    assign b_out      = b_q;
    assign mul_start  = start_q[0];
    assign mulu_start = start_q[1];
    assign div_start  = start_q[2];
    assign divu_start = start_q[3];
    assign hi_wdata   = hi_q;
    assign lo_wdata   = lo_q;
    assign hi_ena     = wr_q;
    assign lo_ena     = wr_q;
    assign done       = wr_q;
    assign err        = err_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed operations push expected
// done/err events; a negedge monitor pops and compares them.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] rs_value, rt_value;
    logic        op_ready, stall;
    logic [31:0] a_out, b_out;
    logic        mul_start, mulu_start, div_start, divu_start;
    logic        mul_done, mulu_done, div_busy, divu_busy;
    logic [63:0] res_mul, res_mulu;
    logic [31:0] res_q, res_r, res_qu, res_ru;
    logic [31:0] hi_wdata, lo_wdata;
    logic        hi_ena, lo_ena, done, err;

    typedef struct packed {
        logic        is_err;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_mul = 0, n_mulu = 0, n_div = 0, n_divu = 0;

    md_sequencer #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .rs_value(rs_value), .rt_value(rt_value),
        .op_ready(op_ready), .stall(stall), .a_out(a_out), .b_out(b_out),
        .mul_start(mul_start), .mulu_start(mulu_start),
        .div_start(div_start), .divu_start(divu_start),
        .mul_done(mul_done), .mulu_done(mulu_done),
        .div_busy(div_busy), .divu_busy(divu_busy),
        .res_mul(res_mul), .res_mulu(res_mulu),
        .res_q(res_q), .res_r(res_r), .res_qu(res_qu), .res_ru(res_ru),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_ena(hi_ena), .lo_ena(lo_ena), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        op_valid = 1'b1;
        op_code  = op;
        rs_value = rs;
        rt_value = rt;
    endtask

    // Start pulse counters
    always @(posedge clk) begin
        if (mul_start)  n_mul  <= n_mul + 1;
        if (mulu_start) n_mulu <= n_mulu + 1;
        if (div_start)  n_div  <= n_div + 1;
        if (divu_start) n_divu <= n_divu + 1;
    end

    // Monitor: every write or abort must match the oldest expected event
    always @(negedge clk) begin
        exp_t e;
        if (done || err || hi_ena || lo_ena) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event done=%0b err=%0b hi_ena=%0b required=none", done, err, hi_ena);
            end else begin
                e = sb_q.pop_front();
                check("event_kind_err", 64'(err), 64'(e.is_err));
                check("event_kind_done", 64'(done), 64'(!e.is_err));
                check("event_hi_ena", 64'(hi_ena), 64'(!e.is_err));
                check("event_lo_ena", 64'(lo_ena), 64'(!e.is_err));
                if (!e.is_err) begin
                    check("hi_wdata", 64'(hi_wdata), 64'(e.hi));
                    check("lo_wdata", 64'(lo_wdata), 64'(e.lo));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_mul, base_div, base_mulu, cycles;
        logic stall_ok, early;

        rst = 1'b1; op_valid = 1'b0; op_code = '0; rs_value = '0; rt_value = '0;
        mul_done = 1'b0; mulu_done = 1'b0; div_busy = 1'b0; divu_busy = 1'b0;
        res_mul = '0; res_mulu = '0; res_q = '0; res_r = '0; res_qu = '0; res_ru = '0;
        tick(); tick();

        // Reset state
        check("rst_op_ready", 64'(op_ready), 64'd1);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_a_out", 64'(a_out), 64'd0);
        check("rst_b_out", 64'(b_out), 64'd0);
        check("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
        check("rst_starts", 64'({mul_start, mulu_start, div_start, divu_start}), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);

        // Reset has priority over a simultaneous request
        issue(2'b00, 32'h1234_5678, 32'h9);
        tick();
        check("rstprio_op_ready", 64'(op_ready), 64'd1);
        check("rstprio_a_out", 64'(a_out), 64'd0);
        check("rstprio_mul_start", 64'(mul_start), 64'd0);
        rst = 1'b0; op_valid = 1'b0;
        tick();

        // MULT -2 * 3, done 3 cycles after start
        base_mul = n_mul;
        sb_q.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        issue(2'b00, 32'hFFFF_FFFE, 32'd3);
        tick();
        op_valid = 1'b0;
        check("mult_start", 64'(mul_start), 64'd1);
        check("mult_other_starts", 64'({mulu_start, div_start, divu_start}), 64'd0);
        check("mult_stall", 64'({stall, op_ready}), 64'b10);
        check("mult_operands", {a_out, b_out}, {32'hFFFF_FFFE, 32'd3});
        tick();
        check("mult_start_one_cycle", 64'(mul_start), 64'd0);
        tick();
        tick();
        mul_done = 1'b1; res_mul = 64'hFFFF_FFFF_FFFF_FFFA;
        tick();
        mul_done = 1'b0;
        check("mult_done_at_n5", 64'(done), 64'd1);
        tick();
        check("mult_done_pulse_width", 64'(done), 64'd0);
        check("mult_ready_after", 64'(op_ready), 64'd1);
        check("mult_start_count", 64'(n_mul - base_mul), 64'd1);

        // DIVU 100/7 with a second request and a stray mul_done during WAIT
        base_mul = n_mul;
        res_qu = 32'd14; res_ru = 32'd2; res_q = 32'hDEAD; res_r = 32'hBEEF;
        sb_q.push_back('{1'b0, 32'd2, 32'd14});
        issue(2'b11, 32'd100, 32'd7);
        tick();
        op_valid = 1'b0;
        check("divu_start", 64'({divu_start, div_start}), 64'b10);
        stall_ok = 1'b1; early = 1'b0;
        for (int i = 0; i < 33; i++) begin
            tick();
            divu_busy = 1'b1;
            if (i == 3) begin
                issue(2'b00, 32'd1, 32'd1);
                mul_done = 1'b1;
            end
            if (i == 4) begin
                op_valid = 1'b0;
                mul_done = 1'b0;
            end
            if (!stall) stall_ok = 1'b0;
            if (done || err) early = 1'b1;
        end
        tick();
        divu_busy = 1'b0;
        check("divu_stall_throughout", 64'({stall_ok, stall}), 64'b11);
        check("divu_no_early_done", 64'({early, done}), 64'd0);
        check("divu_operands_held", {a_out, b_out}, {32'd100, 32'd7});
        tick();
        check("divu_done", 64'(done), 64'd1);
        tick();
        check("divu_ready_after", 64'(op_ready), 64'd1);
        check("divu_ignored_req_no_start", 64'(n_mul - base_mul), 64'd0);

        // DIV by zero
        base_div = n_div;
        sb_q.push_back('{1'b1, 32'd0, 32'd0});
        issue(2'b10, 32'd5, 32'd0);
        tick();
        op_valid = 1'b0;
        check("div0_err", 64'(err), 64'd1);
        check("div0_ready", 64'(op_ready), 64'd1);
        check("div0_no_write", 64'({div_start, hi_ena}), 64'd0);
        tick();
        check("div0_err_one_cycle", 64'(err), 64'd0);
        check("div0_no_start", 64'(n_div - base_div), 64'd0);

        // MULTU timeout with a stray mul_done inside WAIT
        base_mulu = n_mulu;
        sb_q.push_back('{1'b1, 32'd0, 32'd0});
        issue(2'b01, 32'd9, 32'd9);
        tick();
        op_valid = 1'b0;
        check("multu_start", 64'(mulu_start), 64'd1);
        cycles = 1;
        while (!err && cycles < 200) begin
            tick();
            cycles++;
            mul_done = (cycles == 10);
        end
        mul_done = 1'b0;
        check("timeout_err_cycle", 64'(cycles), 64'd66);
        check("timeout_ready", 64'(op_ready), 64'd1);
        tick();
        check("timeout_no_write", 64'({err, hi_ena, lo_ena}), 64'd0);
        check("timeout_single_start", 64'(n_mulu - base_mulu), 64'd1);

        // Reset in the middle of a DIV wait
        base_div = n_div;
        issue(2'b10, 32'd50, 32'd5);
        tick();
        op_valid = 1'b0;
        tick();
        div_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; div_busy = 1'b0;
        check("midrst_ready", 64'({op_ready, stall}), 64'b10);
        check("midrst_operands", {a_out, b_out}, 64'd0);
        check("midrst_hilo", {hi_wdata, lo_wdata}, 64'd0);
        check("midrst_flags", 64'({mul_start, mulu_start, div_start, divu_start, done, err, hi_ena}), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("midrst_no_restart", 64'(n_div - base_div), 64'd1);

        // MULT with minimum latency, stray mulu_done alongside
        sb_q.push_back('{1'b0, 32'h0000_0001, 32'h2345_6789});
        issue(2'b00, 32'h1111, 32'h2222);
        tick();
        op_valid = 1'b0;
        tick();
        mul_done = 1'b1; mulu_done = 1'b1;
        res_mul = 64'h0000_0001_2345_6789; res_mulu = 64'hAAAA_AAAA_BBBB_BBBB;
        tick();
        mul_done = 1'b0; mulu_done = 1'b0;
        check("mult_k1_done", 64'(done), 64'd1);
        tick();
        check("mult_k1_ready", 64'(op_ready), 64'd1);

        // MULTU, done 2 cycles after start
        sb_q.push_back('{1'b0, 32'hCAFE_F00D, 32'h0BAD_BEEF});
        issue(2'b01, 32'h3, 32'h4);
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        mulu_done = 1'b1;
        res_mulu = 64'hCAFE_F00D_0BAD_BEEF; res_mul = 64'h1;
        tick();
        mulu_done = 1'b0;
        check("multu_done", 64'(done), 64'd1);
        tick();
        tick();

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
